// File: rtl/tmds_chan_bond.sv
// Channel-bonding stage for the DVI receive path: per-lane deskew FIFOs aligned on the
// first non-token word after a qualifying control-token run, emitted as lane groups.
module tmds_chan_bond #(
  parameter int NUM_CH    = 3,
  parameter int WORD_W    = 10,
  parameter int DEPTH     = 16,
  parameter int TOKEN_RUN = 4
) (
  input  logic                     pclk,
  input  logic                     rstbtn_n,
  input  logic [NUM_CH-1:0]        ch_vld,
  input  logic [NUM_CH*WORD_W-1:0] ch_data,
  output logic [NUM_CH*WORD_W-1:0] sdout,
  output logic                     data_vld,
  output logic                     data_rdy,
  output logic                     bond_err,
  output logic [7:0]               err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(TOKEN_RUN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, LOCKED = 2'd2} state_t;

  function automatic logic is_token(input logic [WORD_W-1:0] w);
    case (w)
      WORD_W'(10'b1101010100): is_token = 1'b1;
      WORD_W'(10'b0010101011): is_token = 1'b1;
      WORD_W'(10'b0101010100): is_token = 1'b1;
      WORD_W'(10'b1010101011): is_token = 1'b1;
      default:                 is_token = 1'b0;
    endcase
  endfunction

  logic [1:0]              rst_sync_r;
  logic                    rst_n_s;
  logic [WORD_W-1:0]       mem_r [NUM_CH][DEPTH];
  logic [AW:0]             wr_ptr_r [NUM_CH];
  logic [AW:0]             rd_ptr_r [NUM_CH];
  logic [RW-1:0]           run_r [NUM_CH];
  logic [NUM_CH-1:0]       hit_r;
  state_t                  state_r, state_nxt;
  logic [WORD_W-1:0]       head_s [NUM_CH];
  logic [NUM_CH-1:0]       empty_s, full_s, tok_s, marker_s, pop_s, push_s, hit_set_s;
  logic [NUM_CH*WORD_W-1:0] sdout_nxt_s;
  logic                    all_vld_s, all_hit_s, ovf_s, mism_s;
  logic                    flush_s, err_s, emit_s, clr_hit_s;

  // reset button: asserts asynchronously, releases two clocks later on pclk
  always_ff @(posedge pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) rst_sync_r <= 2'b00;
    else           rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_n_s = rst_sync_r[1];

  // per-lane FIFO head status and marker detection
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      head_s[i]   = mem_r[i][rd_ptr_r[i][AW-1:0]];
      empty_s[i]  = (wr_ptr_r[i] == rd_ptr_r[i]);
      full_s[i]   = ((wr_ptr_r[i] - rd_ptr_r[i]) == (AW+1)'(DEPTH));
      tok_s[i]    = is_token(head_s[i]);
      marker_s[i] = !empty_s[i] && !tok_s[i] && (run_r[i] == RW'(TOKEN_RUN));
    end
  end

  assign all_vld_s = &ch_vld;
  assign all_hit_s = &hit_r;
  // a waiting lane that fills up means the skew is larger than the FIFO can absorb
  assign ovf_s     = !all_hit_s && (|(hit_r & full_s));
  assign mism_s    = (|tok_s) && !(&tok_s);

  // bonding state machine: next state, pops, flush and error strobes
  always_comb begin
    state_nxt = state_r;
    flush_s   = 1'b0;
    err_s     = 1'b0;
    emit_s    = 1'b0;
    clr_hit_s = 1'b0;
    pop_s     = '0;
    hit_set_s = '0;
    case (state_r)
      IDLE: begin
        if (all_vld_s) state_nxt = SEARCH;
        else           state_nxt = IDLE;
      end
      SEARCH: begin
        if (!all_vld_s) begin
          flush_s   = 1'b1;
          state_nxt = IDLE;
        end else if (ovf_s) begin
          flush_s = 1'b1;
          err_s   = 1'b1;
        end else if (all_hit_s) begin
          pop_s     = '1;
          emit_s    = 1'b1;
          clr_hit_s = 1'b1;
          state_nxt = LOCKED;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (!hit_r[i] && !empty_s[i]) begin
              if (marker_s[i]) hit_set_s[i] = 1'b1;
              else             pop_s[i]     = 1'b1;
            end else begin
              hit_set_s[i] = 1'b0;
            end
          end
        end
      end
      LOCKED: begin
        if (!all_vld_s) begin
          flush_s   = 1'b1;
          state_nxt = IDLE;
        end else if (!(|empty_s)) begin
          pop_s  = '1;
          emit_s = 1'b1;
          if (mism_s) begin
            err_s     = 1'b1;
            flush_s   = 1'b1;
            state_nxt = SEARCH;
          end else begin
            state_nxt = LOCKED;
          end
        end else begin
          state_nxt = LOCKED;
        end
      end
      default: begin
        flush_s   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // write enables and the group presented to the output register
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state_r != IDLE) && !flush_s && ch_vld[i] && (!full_s[i] || pop_s[i]))
        push_s[i] = 1'b1;
      else
        push_s[i] = 1'b0;
      sdout_nxt_s[i*WORD_W +: WORD_W] = head_s[i];
    end
  end

  // FIFO storage (no reset needed: pointers define what is valid)
  always_ff @(posedge pclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push_s[i]) mem_r[i][wr_ptr_r[i][AW-1:0]] <= ch_data[i*WORD_W +: WORD_W];
    end
  end

  // FIFO pointers, token-run counters and marker hit flags
  always_ff @(posedge pclk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      hit_r <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        run_r[i]    <= '0;
      end
    end else if (flush_s) begin
      hit_r <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        run_r[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + (AW+1)'(1);
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + (AW+1)'(1);
          if (!tok_s[i])                          run_r[i] <= '0;
          else if (run_r[i] != RW'(TOKEN_RUN))    run_r[i] <= run_r[i] + RW'(1);
        end
        if (clr_hit_s)         hit_r[i] <= 1'b0;
        else if (hit_set_s[i]) hit_r[i] <= 1'b1;
      end
    end
  end

  // state register and registered outputs
  always_ff @(posedge pclk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r  <= IDLE;
      sdout    <= '0;
      data_vld <= 1'b0;
      data_rdy <= 1'b0;
      bond_err <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      state_r  <= state_nxt;
      data_vld <= emit_s;
      data_rdy <= (state_nxt == LOCKED);
      bond_err <= err_s;
      if (emit_s) sdout <= sdout_nxt_s;
      if (err_s && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tmds_chan_bond.sv
// Randomised self-checking bench for tmds_chan_bond: per-lane word streams with chosen skews,
// expected groups derived from each stream's first blank->active marker.
module tb_tmds_chan_bond;
  localparam int PRE = 12;
  localparam int TR  = 4;

  logic        pclk, rstbtn_n;
  logic [2:0]  ch_vld;
  logic [29:0] ch_data, sdout;
  logic        data_vld, data_rdy, bond_err;
  logic [7:0]  err_cnt;

  tmds_chan_bond #(.NUM_CH(3), .WORD_W(10), .DEPTH(16), .TOKEN_RUN(TR)) dut (
    .pclk(pclk), .rstbtn_n(rstbtn_n), .ch_vld(ch_vld), .ch_data(ch_data),
    .sdout(sdout), .data_vld(data_vld), .data_rdy(data_rdy), .bond_err(bond_err),
    .err_cnt(err_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic [9:0]  toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0]  lane_q [3][$];
  logic [29:0] obs_d [$];
  int          obs_t [$];
  int          err_t [$];
  logic        rdy_h [$];
  int          rdy_first, rdy_ones, cyc;
  int          vectors = 0, miscompares = 0;
  int          exp_err_cnt = 0;

  function automatic logic is_tok(input logic [9:0] w);
    for (int j = 0; j < 4; j++) if (w == toks[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] rnd_pix();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (is_tok(w));
    return w;
  endfunction

  function automatic logic [9:0] lw(input int i, input int p);
    if (p < lane_q[i].size()) return lane_q[i][p];
    return toks[0];
  endfunction

  function automatic logic [29:0] grp(input int s0, input int s1, input int s2, input int k);
    return {lw(2, s2 + k), lw(1, s1 + k), lw(0, s0 + k)};
  endfunction

  // first non-token word preceded by at least TOKEN_RUN tokens, searching from 'from'
  function automatic int first_marker(input int i, input int from);
    int run = 0;
    for (int p = from; p < lane_q[i].size(); p++) begin
      if (is_tok(lane_q[i][p])) begin
        if (run < TR) run++;
      end else if (run >= TR) return p;
      else run = 0;
    end
    return -1;
  endfunction

  task automatic build(input int sk0, input int sk1, input int sk2, input int nl,
                       input int act, input int blank, input logic f1f0);
    int sk [3];
    sk = '{sk0, sk1, sk2};
    for (int i = 0; i < 3; i++) begin
      lane_q[i].delete();
      for (int p = 0; p < PRE + sk[i]; p++) lane_q[i].push_back(toks[$urandom_range(0, 3)]);
      for (int l = 0; l < nl; l++) begin
        for (int a = 0; a < act; a++)
          lane_q[i].push_back((f1f0 && l == 0 && a == 0) ? 10'h1F0 : rnd_pix());
        for (int b = 0; b < blank; b++) lane_q[i].push_back(toks[$urandom_range(0, 3)]);
      end
    end
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_t.delete(); err_t.delete(); rdy_h.delete();
    rdy_first = -1; rdy_ones = 0; cyc = 0;
  endtask

  task automatic step(input logic [2:0] vm);
    ch_vld = vm;
    for (int i = 0; i < 3; i++) ch_data[i*10 +: 10] = lw(i, cyc);
    @(posedge pclk);
    #1;
    if (data_vld) begin obs_d.push_back(sdout); obs_t.push_back(cyc); end
    if (bond_err) err_t.push_back(cyc);
    rdy_h.push_back(data_rdy);
    if (data_rdy) begin rdy_ones++; if (rdy_first < 0) rdy_first = cyc; end
    cyc++;
  endtask

  task automatic test_reset();
    rstbtn_n = 1'b0; ch_vld = 3'b000; ch_data = '0;
    repeat (3) @(posedge pclk);
    #1;
    vectors++; if (data_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_rdy got %b want 0", data_rdy); end
    vectors++; if (data_vld !== 1'b0) begin miscompares++; $display("FAIL rst_vld got %b want 0", data_vld); end
    vectors++; if (sdout !== 30'd0) begin miscompares++; $display("FAIL rst_sdout got %h want 0", sdout); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_errcnt got %0d want 0", err_cnt); end
    rstbtn_n = 1'b1;
    clear_obs();
    repeat (4) step(3'b000);
    vectors++; if (data_rdy !== 1'b0 || bond_err !== 1'b0) begin
      miscompares++; $display("FAIL rst_idle got rdy=%b err=%b want 0/0", data_rdy, bond_err);
    end
  endtask

  task automatic test_skew();
    int m [3];
    logic [29:0] e;
    clear_obs();
    build(0, 3, 7, 1, 20, 10, 1'b1);
    for (int i = 0; i < 3; i++) m[i] = first_marker(i, 0);
    repeat (60) step(3'b111);
    repeat (2) step(3'b000);
    vectors++; if (rdy_first < 0) begin miscompares++; $display("FAIL t1_lock got rdy never want 1"); end
    e = {10'h1F0, 10'h1F0, 10'h1F0};
    vectors++;
    if (obs_d.size() == 0) begin miscompares++; $display("FAIL t1_first got no group want %h", e); end
    else if (obs_d[0] !== e) begin miscompares++; $display("FAIL t1_first got %h want %h", obs_d[0], e); end
    for (int k = 0; k < obs_d.size(); k++) begin
      vectors++;
      if (obs_d[k] !== grp(m[0], m[1], m[2], k)) begin
        miscompares++; $display("FAIL t1_group k=%0d got %h want %h", k, obs_d[k], grp(m[0], m[1], m[2], k));
      end
    end
    vectors++; if (err_cnt !== 8'd0 || err_t.size() != 0) begin
      miscompares++; $display("FAIL t1_err got cnt=%0d pulses=%0d want 0/0", err_cnt, err_t.size());
    end
  endtask

  task automatic test_lines();
    int m, lat0, bad_lat;
    clear_obs();
    build(0, 0, 0, 3, 640, 160, 1'b0);
    m = first_marker(0, 0);
    repeat (2430) step(3'b111);
    repeat (2) step(3'b000);
    bad_lat = 0;
    lat0 = (obs_t.size() > 0) ? obs_t[0] - m : 0;
    for (int k = 0; k < obs_d.size(); k++) begin
      vectors++;
      if (obs_d[k] !== grp(m, m, m, k)) begin
        miscompares++; $display("FAIL t2_group k=%0d got %h want %h", k, obs_d[k], grp(m, m, m, k));
      end
      if (obs_t[k] - (m + k) != lat0) bad_lat++;
    end
    vectors++; if (obs_d.size() < 2000) begin miscompares++; $display("FAIL t2_count got %0d want >=2000", obs_d.size()); end
    vectors++; if (bad_lat != 0 || lat0 < 1 || lat0 > 17) begin
      miscompares++; $display("FAIL t2_latency got lat0=%0d varying=%0d want fixed", lat0, bad_lat);
    end
    vectors++; if (rdy_ones != obs_d.size()) begin
      miscompares++; $display("FAIL t2_vld_every got rdy=%0d vld=%0d want equal", rdy_ones, obs_d.size());
    end
    vectors++; if (err_t.size() != 0) begin miscompares++; $display("FAIL t2_err got %0d want 0", err_t.size()); end
  endtask

  task automatic test_mismatch();
    int m1, m2, inj, e, n1, n2;
    clear_obs();
    build(0, 0, 0, 3, 30, 20, 1'b0);
    inj = PRE + 30 + 6;
    lane_q[2][inj] = rnd_pix();
    m1 = first_marker(0, 0);
    m2 = first_marker(2, inj + 1);
    repeat (170) step(3'b111);
    repeat (2) step(3'b000);
    exp_err_cnt = exp_err_cnt + 1;
    vectors++; if (err_t.size() != 1) begin miscompares++; $display("FAIL t3_pulses got %0d want 1", err_t.size()); end
    vectors++; if (err_cnt !== 8'(exp_err_cnt)) begin miscompares++; $display("FAIL t3_errcnt got %0d want %0d", err_cnt, exp_err_cnt); end
    e = (err_t.size() > 0) ? err_t[0] : 0;
    vectors++; if (rdy_h[e] !== 1'b0) begin miscompares++; $display("FAIL t3_rdy_drop got %b want 0", rdy_h[e]); end
    n1 = 0; n2 = 0;
    for (int k = 0; k < obs_d.size(); k++) begin
      vectors++;
      if (obs_t[k] <= e) begin
        if (obs_d[k] !== grp(m1, m1, m1, n1)) begin
          miscompares++; $display("FAIL t3_seg1 k=%0d got %h want %h", n1, obs_d[k], grp(m1, m1, m1, n1));
        end
        n1++;
      end else begin
        if (obs_d[k] !== grp(m2, m2, m2, n2)) begin
          miscompares++; $display("FAIL t3_seg2 k=%0d got %h want %h", n2, obs_d[k], grp(m2, m2, m2, n2));
        end
        n2++;
      end
    end
    vectors++; if (n1 != inj - m1 + 1) begin miscompares++; $display("FAIL t3_seg1_len got %0d want %0d", n1, inj - m1 + 1); end
    vectors++; if (n2 < 20) begin miscompares++; $display("FAIL t3_relock got %0d groups want >=20", n2); end
  endtask

  task automatic test_overflow();
    clear_obs();
    build(0, 15, 0, 4, 24, 16, 1'b0);
    repeat (200) step(3'b111);
    repeat (2) step(3'b000);
    exp_err_cnt = exp_err_cnt + err_t.size();
    vectors++; if (err_t.size() < 2) begin miscompares++; $display("FAIL t4_pulses got %0d want >=2", err_t.size()); end
    vectors++; if (rdy_ones != 0 || obs_d.size() != 0) begin
      miscompares++; $display("FAIL t4_nolock got rdy=%0d groups=%0d want 0/0", rdy_ones, obs_d.size());
    end
    vectors++; if (err_cnt !== 8'(exp_err_cnt)) begin miscompares++; $display("FAIL t4_errcnt got %0d want %0d", err_cnt, exp_err_cnt); end
  endtask

  task automatic test_async_reset();
    int m;
    clear_obs();
    build(0, 0, 0, 3, 30, 20, 1'b0);
    repeat (40) step(3'b111);
    vectors++; if (data_rdy !== 1'b1) begin miscompares++; $display("FAIL t5_locked got %b want 1", data_rdy); end
    #3 rstbtn_n = 1'b0;
    #1;
    vectors++; if (data_rdy !== 1'b0 || data_vld !== 1'b0 || bond_err !== 1'b0) begin
      miscompares++; $display("FAIL t5_async got rdy=%b vld=%b err=%b want 000", data_rdy, data_vld, bond_err);
    end
    vectors++; if (sdout !== 30'd0 || err_cnt !== 8'd0) begin
      miscompares++; $display("FAIL t5_async_data got sdout=%h cnt=%0d want 0/0", sdout, err_cnt);
    end
    exp_err_cnt = 0;
    repeat (3) step(3'b000);
    rstbtn_n = 1'b1;
    repeat (4) step(3'b000);
    clear_obs();
    build(0, 0, 0, 3, 30, 20, 1'b0);
    m = first_marker(0, 0);
    repeat (80) step(3'b111);
    repeat (2) step(3'b000);
    vectors++; if (rdy_first < 0) begin miscompares++; $display("FAIL t5_relock got rdy never want 1"); end
    for (int k = 0; k < obs_d.size(); k++) begin
      vectors++;
      if (obs_d[k] !== grp(m, m, m, k)) begin
        miscompares++; $display("FAIL t5_group k=%0d got %h want %h", k, obs_d[k], grp(m, m, m, k));
      end
    end
    vectors++; if (err_cnt !== 8'd0 || err_t.size() != 0) begin
      miscompares++; $display("FAIL t5_err got cnt=%0d pulses=%0d want 0/0", err_cnt, err_t.size());
    end
  endtask

  task automatic test_vld_drop();
    int m1, m2, d, n1, n2;
    clear_obs();
    build(0, 0, 0, 3, 30, 20, 1'b0);
    d = PRE + 10;
    m1 = first_marker(0, 0);
    m2 = first_marker(0, d + 1);
    for (int c = 0; c < 140; c++) begin
      step((c == d) ? 3'b101 : 3'b111);
      if (c == d) begin
        vectors++; if (data_rdy !== 1'b0) begin miscompares++; $display("FAIL t6_rdy_drop got %b want 0", data_rdy); end
      end
    end
    repeat (2) step(3'b000);
    vectors++; if (rdy_first < 0 || rdy_first >= d) begin miscompares++; $display("FAIL t6_lock_before got %0d want <%0d", rdy_first, d); end
    vectors++; if (err_t.size() != 0 || err_cnt !== 8'(exp_err_cnt)) begin
      miscompares++; $display("FAIL t6_no_err got pulses=%0d cnt=%0d want 0/%0d", err_t.size(), err_cnt, exp_err_cnt);
    end
    n1 = 0; n2 = 0;
    for (int k = 0; k < obs_d.size(); k++) begin
      vectors++;
      if (obs_t[k] < d) begin
        if (obs_d[k] !== grp(m1, m1, m1, n1)) begin
          miscompares++; $display("FAIL t6_seg1 k=%0d got %h want %h", n1, obs_d[k], grp(m1, m1, m1, n1));
        end
        n1++;
      end else begin
        if (obs_d[k] !== grp(m2, m2, m2, n2)) begin
          miscompares++; $display("FAIL t6_seg2 k=%0d got %h want %h", n2, obs_d[k], grp(m2, m2, m2, n2));
        end
        n2++;
      end
    end
    vectors++; if (n2 < 20) begin miscompares++; $display("FAIL t6_relock got %0d groups want >=20", n2); end
  endtask

  initial begin
    test_reset();
    test_skew();
    test_lines();
    test_mismatch();
    test_overflow();
    test_async_reset();
    test_vld_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
